// File: rtl/vga_frame_table_ctrl_if.sv
// Bus between the camera/VGA framing signals and the frame-table controller.
//   master: drives the camera capture and VGA timing inputs, receives the display outputs
//   slave : the controller itself
//   cam_vsync/cam_href/pixel_in : camera frame sync, line valid, pixel
//   vga_vsync/bright            : VGA vertical sync (active low), active-video window
//   pixel_out/frame_ready/rd_bank/wr_overflow : display pixel and status
interface vga_frame_table_ctrl_if #(
    parameter int PIXEL_W = 2
);
    logic               cam_vsync;
    logic               cam_href;
    logic [PIXEL_W-1:0] pixel_in;
    logic               vga_vsync;
    logic               bright;
    logic [PIXEL_W-1:0] pixel_out;
    logic               frame_ready;
    logic               rd_bank;
    logic               wr_overflow;

    modport master (
        output cam_vsync, cam_href, pixel_in, vga_vsync, bright,
        input  pixel_out, frame_ready, rd_bank, wr_overflow
    );

    modport slave (
        input  cam_vsync, cam_href, pixel_in, vga_vsync, bright,
        output pixel_out, frame_ready, rd_bank, wr_overflow
    );
endinterface

// File: rtl/vga_frame_table_ctrl.sv
// Frame-buffer controller between camera capture and VGA timing.
// Camera pixels are decimated by W_DIV and written into an inferred dual-port
// RAM; the display side replicates each stored pixel R_REP clocks and each
// stored line L_REP VGA lines. With DOUBLE_BUF=1 two banks ping-pong and swap
// only on a falling vga_vsync once a complete frame has been written.
//   clk_25  : pixel clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : framing inputs and display outputs (vga_frame_table_ctrl_if.slave)
module vga_frame_table_ctrl #(
    parameter int PIXEL_W    = 2,
    parameter int SRC_W      = 640,
    parameter int SRC_H      = 240,
    parameter int W_DIV      = 2,
    parameter int R_REP      = 2,
    parameter int L_REP      = 2,
    parameter int DOUBLE_BUF = 1
) (
    input  logic                  clk_25,
    input  logic                  reset_n,
    vga_frame_table_ctrl_if.slave bus
);
    localparam int STORE_W = SRC_W / W_DIV;
    localparam int DEPTH   = STORE_W * SRC_H;
    localparam int AW      = $clog2(DEPTH) + DOUBLE_BUF;
    localparam int NBANK   = DOUBLE_BUF + 1;
    localparam int CW      = $clog2(STORE_W + 1);
    localparam int RW      = $clog2(SRC_H + 1);
    localparam int WPW     = (W_DIV > 1) ? $clog2(W_DIV) : 1;
    localparam int RPW     = (R_REP > 1) ? $clog2(R_REP) : 1;
    localparam int LPW     = (L_REP > 1) ? $clog2(L_REP) : 1;

    localparam logic [CW-1:0]  COL_END   = CW'(STORE_W);
    localparam logic [RW-1:0]  ROW_END   = RW'(SRC_H);
    localparam logic [RW-1:0]  ROW_LAST  = RW'(SRC_H - 1);
    localparam logic [WPW-1:0] WPH_LAST  = WPW'(W_DIV - 1);
    localparam logic [RPW-1:0] RPH_LAST  = RPW'(R_REP - 1);
    localparam logic [LPW-1:0] LREP_LAST = LPW'(L_REP - 1);
    localparam logic [AW-1:0]  LINE_STEP = AW'(STORE_W);
    localparam logic [AW-1:0]  BANK_OFS  = AW'(DEPTH);

    logic [PIXEL_W-1:0] mem [NBANK*DEPTH];

    logic cam_vsync_d, cam_href_d, bright_d, vga_vsync_d;
    logic cam_vs_rise, href_fall, bright_fall, vga_vs_fall;

    logic [CW-1:0]  wcol, rcol;
    logic [RW-1:0]  wrow, rrow;
    logic [WPW-1:0] w_phase;
    logic [RPW-1:0] r_phase;
    logic [LPW-1:0] l_rep;
    logic [AW-1:0]  wline_base, rline_base, waddr, raddr;
    logic           wbank, rd_bank_q, frame_ready_q, wr_done, wr_overflow_q;
    logic           pix_slot, row_ok, we, ovf, wr_done_set, swap;
    logic           rd_valid;
    logic [PIXEL_W-1:0] rd_data;

    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            cam_vsync_d <= 1'b0;
            cam_href_d  <= 1'b0;
            bright_d    <= 1'b0;
            vga_vsync_d <= 1'b1;
        end else begin
            cam_vsync_d <= bus.cam_vsync;
            cam_href_d  <= bus.cam_href;
            bright_d    <= bus.bright;
            vga_vsync_d <= bus.vga_vsync;
        end
    end

    always_comb begin
        cam_vs_rise = bus.cam_vsync && !cam_vsync_d;
        href_fall   = cam_href_d && !bus.cam_href;
        bright_fall = bright_d && !bus.bright;
        vga_vs_fall = vga_vsync_d && !bus.vga_vsync;
        pix_slot    = bus.cam_href && !cam_vs_rise && (w_phase == '0);
        row_ok      = (wrow < ROW_END);
        we          = pix_slot && row_ok && (wcol < COL_END);
        // On a line past the frame, wcol still advances so only the first
        // kept-phase pixel of that line raises the overflow pulse.
        ovf         = pix_slot && (row_ok ? (wcol == COL_END) : (wcol == '0));
        wr_done_set = href_fall && !cam_vs_rise && (wrow == ROW_LAST);
        // A frame that completes in the same cycle as vsync still swaps.
        swap        = vga_vs_fall && (wr_done || wr_done_set);
        waddr       = (wbank ? BANK_OFS : '0) + wline_base + AW'(wcol);
        raddr       = (rd_bank_q ? BANK_OFS : '0) + rline_base + AW'(rcol);
    end

    // Write side
    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            wcol          <= '0;
            wrow          <= '0;
            w_phase       <= '0;
            wline_base    <= '0;
            wr_overflow_q <= 1'b0;
        end else begin
            wr_overflow_q <= ovf;
            if (cam_vs_rise) begin
                wcol       <= '0;
                wrow       <= '0;
                w_phase    <= '0;
                wline_base <= '0;
            end else if (href_fall) begin
                wcol    <= '0;
                w_phase <= '0;
                if (row_ok) begin
                    wrow       <= wrow + 1'b1;
                    wline_base <= wline_base + LINE_STEP;
                end
            end else if (bus.cam_href) begin
                w_phase <= (w_phase == WPH_LAST) ? '0 : w_phase + 1'b1;
                if (pix_slot && (wcol < COL_END))
                    wcol <= wcol + 1'b1;
            end
        end
    end

    // Bank control
    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            wbank         <= 1'(DOUBLE_BUF);
            rd_bank_q     <= 1'b0;
            frame_ready_q <= 1'b0;
            wr_done       <= 1'b0;
        end else begin
            if (swap) begin
                wr_done       <= 1'b0;
                frame_ready_q <= 1'b1;
                if (DOUBLE_BUF != 0) begin
                    rd_bank_q <= wbank;
                    wbank     <= ~wbank;
                end
            end else if (cam_vs_rise) begin
                wr_done <= 1'b0;
            end else if (wr_done_set) begin
                wr_done <= 1'b1;
            end
        end
    end

    // Read side
    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            rcol       <= '0;
            rrow       <= '0;
            r_phase    <= '0;
            l_rep      <= '0;
            rline_base <= '0;
            rd_valid   <= 1'b0;
        end else begin
            rd_valid <= bus.bright && frame_ready_q && (rcol < COL_END);
            if (vga_vs_fall) begin
                rcol       <= '0;
                rrow       <= '0;
                r_phase    <= '0;
                l_rep      <= '0;
                rline_base <= '0;
            end else if (bright_fall) begin
                rcol    <= '0;
                r_phase <= '0;
                if (l_rep == LREP_LAST) begin
                    l_rep <= '0;
                    if (rrow == ROW_LAST) begin
                        rrow       <= '0;
                        rline_base <= '0;
                    end else begin
                        rrow       <= rrow + 1'b1;
                        rline_base <= rline_base + LINE_STEP;
                    end
                end else begin
                    l_rep <= l_rep + 1'b1;
                end
            end else if (bus.bright) begin
                if (r_phase == RPH_LAST) begin
                    r_phase <= '0;
                    if (rcol < COL_END)
                        rcol <= rcol + 1'b1;
                end else begin
                    r_phase <= r_phase + 1'b1;
                end
            end
        end
    end

    // RAM: the read register stays reset-free so it maps onto block RAM;
    // the registered rd_valid qualifier carries the reset and blanking.
    always_ff @(posedge clk_25) begin
        if (we)
            mem[waddr] <= bus.pixel_in;
        rd_data <= mem[raddr];
    end

    always_comb begin
        bus.pixel_out   = rd_valid ? rd_data : '0;
        bus.frame_ready = frame_ready_q;
        bus.rd_bank     = rd_bank_q;
        bus.wr_overflow = wr_overflow_q;
    end
endmodule

// File: doc/vga_frame_table_ctrl.md
Name: vga_frame_table_ctrl

Overview:
- Parametrised frame-buffer controller between the camera capture path and the VGA timing generator.
- Write side decimates camera pixels horizontally by W_DIV and stores them in an internal inferred dual-port RAM.
- Read side replicates each stored pixel R_REP clocks horizontally and each stored line L_REP VGA lines vertically.
- Optional ping-pong double buffering; banks swap only at VGA vertical sync, so no tearing. All framing inputs are sampled synchronously, never used as resets.

Parameters:
PIXEL_W, 2, bits per pixel
SRC_W, 640, camera pixels per line
SRC_H, 240, camera lines per frame
W_DIV, 2, keep 1 of every W_DIV input pixels (>=1)
R_REP, 2, clocks each stored pixel is output (>=1)
L_REP, 2, VGA lines each stored line is repeated (>=1)
DOUBLE_BUF, 1, 1 = two banks ping-pong, 0 = single bank
Derived: STORE_W=SRC_W/W_DIV; DEPTH=STORE_W*SRC_H; AW=clog2(DEPTH)+DOUBLE_BUF

Ports:
clk_25  in  1  pixel clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
cam_vsync  in  1  camera frame sync; rising edge starts a frame
cam_href  in  1  high while valid camera pixels of a line are present
pixel_in  in  PIXEL_W  camera pixel, valid when cam_href=1
vga_vsync  in  1  VGA vertical sync, active low
bright  in  1  VGA active-video window
pixel_out  out  PIXEL_W  displayed pixel
frame_ready  out  1  high once a complete frame has been made readable
rd_bank  out  1  bank currently read (0 when DOUBLE_BUF=0)
wr_overflow  out  1  one-cycle pulse when an input pixel or line is dropped

Behaviour:
Reset:
- Counters, phases, pixel_out, frame_ready, wr_overflow and rd_bank all return to 0.
- Write bank returns to 1 (0 if DOUBLE_BUF=0).
- Edge-detect registers return to: cam_vsync_d=0, cam_href_d=0, bright_d=0, vga_vsync_d=1.
- Reset mid-frame abandons the frame; no partial swap occurs.

Write side:
- Rising cam_vsync clears wcol, wrow, w_phase and wr_done.
- While cam_href=1:
  - w_phase counts 0..W_DIV-1 and wraps.
  - Memory write occurs when w_phase==0, wcol<STORE_W and wrow<SRC_H, at address wbank*DEPTH + wline_base + wcol; wcol is then incremented.
  - wline_base is an incremental register; no multiplier.
- If w_phase==0 and wcol==STORE_W, the pixel is dropped and wr_overflow pulses.
- Falling cam_href:
  - wcol=0, w_phase=0, wline_base+=STORE_W, wrow++.
  - When wrow reaches SRC_H, wr_done=1.
  - Any line arriving with wrow>=SRC_H is dropped; wr_overflow pulses once on that line's first kept-phase pixel.

Bank swap:
- On a falling vga_vsync with wr_done=1: rd_bank<=wbank, wbank toggles (DOUBLE_BUF=1), wr_done=0, frame_ready=1 (sticky until reset).
- If wr_done=0, there is no swap and the old bank is re-displayed.
- If wr_done rises and vga_vsync falls in the same cycle, the swap happens.
- With DOUBLE_BUF=0, frame_ready is set but the bank never changes.

Read side:
- Falling vga_vsync clears rcol, rrow, r_phase, l_rep and rline_base.
- While bright=1:
  - r_phase counts 0..R_REP-1.
  - At R_REP-1, rcol++; rcol saturates at STORE_W.
- Falling bright:
  - rcol=0, r_phase=0, l_rep++.
  - When l_rep==L_REP-1, l_rep=0, rrow++, rline_base+=STORE_W.
  - When rrow reaches SRC_H, it wraps to 0 and rline_base to 0.
- Read address = rd_bank*DEPTH + rline_base + rcol.

Output:
- RAM read is synchronous; pixel_out is registered.
- pixel_out lags bright by exactly 1 cycle.
- pixel_out = 0 when any of: bright_d=0, frame_ready=0, or rcol>=STORE_W.

Other:
- Read and write of the same address in the same cycle never occurs in valid double-buffered operation.
- With DOUBLE_BUF=0, the read returns old data (tearing accepted).

Test Plan:
Params for all tests: SRC_W=8, SRC_H=4, W_DIV=2, R_REP=2, L_REP=2.
1. Write one frame:
   - Stimulus: pixel_in = input index mod 4; 4 lines of 8 pixels.
   - Required: RAM holds 0,2,0,2 per line; wr_done=1 after the 4th href fall.
2. Then a falling vga_vsync:
   - Required: rd_bank=1, frame_ready=1.
   - With bright high for 8 clocks, pixel_out = 0,0,2,2,0,0,2,2, starting 1 cycle after bright rises.
3. Line repetition:
   - Stimulus: 8 VGA lines.
   - Required: each stored row is output twice; rrow wraps to 0 on the 9th line.
4. Before any frame is complete:
   - Stimulus: bright pulses.
   - Required: pixel_out=0, frame_ready=0.
   - Also: vga_vsync falling while wr_done=0 leaves rd_bank unchanged.
5. Overflow:
   - Stimulus: a 10-pixel href line.
   - Required: one wr_overflow pulse, only 4 pixels stored.
   - Stimulus: a 5th line in the frame.
   - Required: a wr_overflow pulse, and the RAM is unchanged.
6. Reset mid-operation:
   - Stimulus: assert reset_n=0 mid-line during a write, release, then write a full new frame.
   - Required: all outputs 0 during reset, and the first vsync after the new frame swaps to bank 1.
